// File: rtl/time_display_scan_pkg.sv
// Shared constants and helpers for the multiplexed time display.
package time_display_scan_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam int         IDX_W      = 3;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'h3F;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'b00,
        FIELD_SEC  = 2'b01,
        FIELD_MIN  = 2'b10,
        FIELD_HOUR = 2'b11
    } field_e;

    // Field that owns a given digit position (two digits per field).
    function automatic field_e field_of_idx(input logic [IDX_W-1:0] idx);
        field_e f;
        case (idx)
            3'd0, 3'd1: f = FIELD_SEC;
            3'd2, 3'd3: f = FIELD_MIN;
            3'd4, 3'd5: f = FIELD_HOUR;
            default:    f = FIELD_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/time_display_scan_if.sv
// Bundle between the BCD counter chain / set-mode keys and the display scanner.
interface time_display_scan_if;
    logic [7:0] second_bcd;
    logic [7:0] minute_bcd;
    logic [7:0] hour_bcd;
    logic       set;
    logic [1:0] field_sel;
    logic [5:0] digit_en;
    logic [6:0] seg;
    logic       dp;

    // Counter/keys side: supplies time and edit state, watches the pins.
    modport master (
        output second_bcd, minute_bcd, hour_bcd, set, field_sel,
        input  digit_en, seg, dp
    );

    // Scanner side.
    modport slave (
        input  second_bcd, minute_bcd, hour_bcd, set, field_sel,
        output digit_en, seg, dp
    );
endinterface

// File: rtl/time_display_scan_bcd_to_seg7.sv
// Nibble to active-low gfedcba pattern; non-BCD nibbles render as a dash.
module bcd_to_seg7
    import time_display_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Pure decode table.
    always_comb begin
        seg_o = SEG_DASH;
        case (nibble_i)
            4'd0:    seg_o = 7'h40;
            4'd1:    seg_o = 7'h79;
            4'd2:    seg_o = 7'h24;
            4'd3:    seg_o = 7'h30;
            4'd4:    seg_o = 7'h19;
            4'd5:    seg_o = 7'h12;
            4'd6:    seg_o = 7'h02;
            4'd7:    seg_o = 7'h78;
            4'd8:    seg_o = 7'h00;
            4'd9:    seg_o = 7'h10;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/time_display_scan.sv
// Scans six BCD digits (SS MM HH) onto one 7-segment bus with field blinking.
module time_display_scan
    import time_display_scan_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int SCAN_HZ       = 1000,
    parameter int BLINK_HZ      = 2,
    parameter bit HOUR_LZ_BLANK = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    time_display_scan_if.slave   bus
);

    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int SCAN_W    = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [5:0]         digit_en_q, digit_en_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;
    logic [3:0]         nibble_s;
    logic [6:0]         seg_dec_s;
    logic               blink_blank_s;
    logic               lz_blank_s;

    bcd_to_seg7 u_dec (
        .nibble_i (nibble_s),
        .seg_o    (seg_dec_s)
    );

    // Prescalers and digit index: wrap at terminal count, scan advances on its wrap.
    always_comb begin
        scan_cnt_d    = scan_cnt_q + SCAN_W'(1);
        idx_d         = idx_q;
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            if (idx_q == 3'd5) begin
                idx_d = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        end
    end

    // Digit select, blanking and decimal point for the digit currently indexed.
    always_comb begin
        nibble_s   = 4'd0;
        digit_en_d = 6'b000000;
        case (idx_q)
            3'd0:    begin nibble_s = bus.second_bcd[3:0]; digit_en_d = 6'b000001; end
            3'd1:    begin nibble_s = bus.second_bcd[7:4]; digit_en_d = 6'b000010; end
            3'd2:    begin nibble_s = bus.minute_bcd[3:0]; digit_en_d = 6'b000100; end
            3'd3:    begin nibble_s = bus.minute_bcd[7:4]; digit_en_d = 6'b001000; end
            3'd4:    begin nibble_s = bus.hour_bcd[3:0];   digit_en_d = 6'b010000; end
            3'd5:    begin nibble_s = bus.hour_bcd[7:4];   digit_en_d = 6'b100000; end
            default: begin nibble_s = 4'd0;                digit_en_d = 6'b000000; end
        endcase

        // The edited field goes dark during the second blink phase only.
        blink_blank_s = bus.set && (bus.field_sel != FIELD_NONE)
                        && (bus.field_sel == field_of_idx(idx_q))
                        && blink_phase_q;
        lz_blank_s    = HOUR_LZ_BLANK && (idx_q == 3'd5)
                        && (bus.hour_bcd[7:4] == 4'd0);

        if (blink_blank_s || lz_blank_s) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_dec_s;
        end

        // Separators sit on the units digits of minutes and hours.
        if ((idx_q == 3'd2) || (idx_q == 3'd4)) begin
            dp_d = 1'b0;
        end else begin
            dp_d = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            scan_cnt_q    <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            idx_q         <= 3'd0;
            digit_en_q    <= 6'b000000;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            idx_q         <= idx_d;
            digit_en_q    <= digit_en_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign bus.digit_en = digit_en_q;
    assign bus.seg      = seg_q;
    assign bus.dp       = dp_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench: SCAN_DIV=3, BLINK_DIV=6; two instances differ only in hour leading-zero blanking.
module tb_time_display_scan;

    logic clock;
    logic reset;
    int   tests_run;
    int   tests_failed;

    logic [6:0] exp_seg_a [6];
    logic [6:0] exp_seg_b [6];

    time_display_scan_if bus_a ();
    time_display_scan_if bus_b ();

    time_display_scan #(
        .CLK_HZ(12), .SCAN_HZ(4), .BLINK_HZ(1), .HOUR_LZ_BLANK(1'b1)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    time_display_scan #(
        .CLK_HZ(12), .SCAN_HZ(4), .BLINK_HZ(1), .HOUR_LZ_BLANK(1'b0)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One active edge, then sample on the falling edge.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                         input logic st, input logic [1:0] fs);
        bus_a.second_bcd = s; bus_a.minute_bcd = m; bus_a.hour_bcd = h;
        bus_a.set = st; bus_a.field_sel = fs;
        bus_b.second_bcd = s; bus_b.minute_bcd = m; bus_b.hour_bcd = h;
        bus_b.set = st; bus_b.field_sel = fs;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, ".en"},  32'(bus_a.digit_en), 32'h00);
        check_value({tag, ".seg"}, 32'(bus_a.seg),      32'h7F);
        check_value({tag, ".dp"},  32'(bus_a.dp),       32'h1);
        check_value({tag, ".en_b"}, 32'(bus_b.digit_en), 32'h00);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_reset_outputs(tag);
        reset = 1'b1;
    endtask

    // Walks n edges after reset release; edge k shows digit (k-1)/3 mod 6,
    // blink phase is (k-1)/6 mod 2, masked digits go dark in phase 1.
    task automatic run_and_check(input string tag, input int n_edges, input logic [5:0] blink_mask);
        for (int k = 1; k <= n_edges; k++) begin
            int         idx;
            logic       phase;
            logic [6:0] ea, eb;
            logic       edp;
            step();
            idx   = ((k - 1) / 3) % 6;
            phase = (((k - 1) / 6) % 2) == 1;
            ea    = (blink_mask[idx] && phase) ? 7'h7F : exp_seg_a[idx];
            eb    = (blink_mask[idx] && phase) ? 7'h7F : exp_seg_b[idx];
            edp   = !((idx == 2) || (idx == 4));
            check_value($sformatf("%s.en[k=%0d]", tag, k),    32'(bus_a.digit_en), 32'(6'b000001 << idx));
            check_value($sformatf("%s.seg[k=%0d]", tag, k),   32'(bus_a.seg),      32'(ea));
            check_value($sformatf("%s.dp[k=%0d]", tag, k),    32'(bus_a.dp),       32'(edp));
            check_value($sformatf("%s.seg_b[k=%0d]", tag, k), 32'(bus_b.seg),      32'(eb));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        drive(8'h59, 8'h07, 8'h23, 1'b0, 2'b00);

        // 1: basic scan order, decode, separators, wrap.
        exp_seg_a = '{7'h10, 7'h12, 7'h78, 7'h40, 7'h30, 7'h24};
        exp_seg_b = exp_seg_a;
        do_reset("t1.rst");
        run_and_check("t1", 19, 6'b000000);

        // 2: hour 05 -> leading zero blanked only when enabled.
        drive(8'h59, 8'h07, 8'h05, 1'b0, 2'b00);
        exp_seg_a = '{7'h10, 7'h12, 7'h78, 7'h40, 7'h12, 7'h7F};
        exp_seg_b = '{7'h10, 7'h12, 7'h78, 7'h40, 7'h12, 7'h40};
        do_reset("t2.rst");
        run_and_check("t2", 18, 6'b000000);

        // 3: editing minutes blinks only the minute digits.
        drive(8'h59, 8'h34, 8'h23, 1'b1, 2'b10);
        exp_seg_a = '{7'h10, 7'h12, 7'h19, 7'h30, 7'h30, 7'h24};
        exp_seg_b = exp_seg_a;
        do_reset("t3.rst");
        run_and_check("t3", 36, 6'b001100);

        // 4: invalid BCD tens nibble shows a dash.
        drive(8'hA3, 8'h07, 8'h23, 1'b0, 2'b00);
        exp_seg_a = '{7'h30, 7'h3F, 7'h78, 7'h40, 7'h30, 7'h24};
        exp_seg_b = exp_seg_a;
        do_reset("t4.rst");
        run_and_check("t4", 18, 6'b000000);

        // 5: reset in the middle of digit 4, then restart from digit 0.
        drive(8'h59, 8'h07, 8'h23, 1'b0, 2'b00);
        exp_seg_a = '{7'h10, 7'h12, 7'h78, 7'h40, 7'h30, 7'h24};
        exp_seg_b = exp_seg_a;
        do_reset("t5.rst");
        for (int i = 0; i < 13; i++) step();
        check_value("t5.pre_en", 32'(bus_a.digit_en), 32'h10);
        reset = 1'b0;
        step();
        check_reset_outputs("t5.mid");
        reset = 1'b1;
        run_and_check("t5.restart", 6, 6'b000000);

        // 6: leaving set mode un-blanks the seconds digit on the next edge.
        drive(8'h59, 8'h07, 8'h23, 1'b1, 2'b01);
        do_reset("t6.rst");
        run_and_check("t6", 19, 6'b000011);
        drive(8'h59, 8'h07, 8'h23, 1'b0, 2'b01);
        step();
        check_value("t6.unblank_en",  32'(bus_a.digit_en), 32'h01);
        check_value("t6.unblank_seg", 32'(bus_a.seg),      32'h10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
